rr_arbiter_4x4bit: RTL and testbench

Four-channel round-robin arbiter with a one-entry registered output stage. It sits directly upstream of the 4-to-1, 4-bit multiplexer datapath. It decides which of four 4-bit sources is forwarded and drives the 2-bit select (`sel`, binary channel index, 0 selects `a` through 3 selects `d`). It holds the selected word in an output register under a valid/ready handshake, so the select input is never left to free-run or be hand-driven.

---
 rtl/rr_arbiter_4x4bit.sv | 116 +++++++++++
 tb/tb_rr_arbiter_4x4bit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4x4bit.sv
// rr_arbiter_4x4bit
//   Four-channel round-robin arbiter with a one-entry registered output stage.
//   It picks one of four WIDTH-bit sources, captures the word into an output
//   register under a valid/ready handshake, and drives the 2-bit mux select.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : per-channel request (bit 0 = a ... bit 3 = d)
//   a,b,c,d    : channel data, valid while the matching req bit is high
//   gnt[3:0]   : one-hot, combinational; channel accepted at the coming edge
//   sel[1:0]   : registered index of the channel whose word is in out_data
//   out_valid  : registered; out_data holds an unconsumed word
//   out_data   : registered captured word
//   out_ready  : downstream consumes out_data on an edge with out_valid high
module rr_arbiter_4x4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_data;

    logic             w_space;
    logic             w_found;
    logic             w_accept;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic [WIDTH-1:0] w_win_data;

    assign out_valid = (r_state == ST_FULL);
    assign sel       = r_sel;
    assign out_data  = r_data;

    assign w_space  = !out_valid || out_ready;
    // Gating with rst_n keeps gnt low while reset is held, so a requester
    // never sees a grant that the reset is about to discard.
    assign w_accept = rst_n && w_space && w_found;
    assign gnt      = w_accept ? (4'b0001 << w_win) : 4'b0000;

    // Search upward from the pointer with 2-bit wrap; the first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_data = a;
        case (w_win)
            2'd0:    w_win_data = a;
            2'd1:    w_win_data = b;
            2'd2:    w_win_data = c;
            default: w_win_data = d;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data, select and pointer move only on accept; a stall or a drain
    // leaves them untouched so the mux output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 2'd0;
            r_sel  <= 2'd0;
            r_data <= '0;
        end else if (w_accept) begin
            r_ptr  <= w_win + 2'd1;
            r_sel  <= w_win;
            r_data <= w_win_data;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4x4bit.sv
`timescale 1ns/1ps
module tb_rr_arbiter_4x4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    // Expected words, {sel, data}, in the order they will be consumed.
    logic [5:0] exp_q[$];

    rr_arbiter_4x4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] dat);
        exp_q.push_back({s, dat});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word shown with out_valid && out_ready at the negedge is
    // consumed at the next rising edge (inputs only change just after posedge).
    always @(negedge clk) begin
        logic [5:0] e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", {sel, out_data});
            end else begin
                e = exp_q.pop_front();
                if ({sel, out_data} !== e) begin
                    failures++;
                    $display("FAIL sb_word actual=%0h expected=%0h", {sel, out_data}, e);
                end
            end
        end
    end

    initial begin
        int wins[6] = '{1, 2, 3, 0, 1, 2};

        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        #3;
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_data",  {4'd0, out_data},  8'd0);
        chk("rst_sel",   {6'd0, sel},       8'd0);
        chk("rst_gnt",   {4'd0, gnt},       8'd0);

        // Release and first grant from pointer 0
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("first_gnt", {4'd0, gnt}, 8'h01);
        push(2'd0, 4'h1);
        step();
        chk("first_sel",   {6'd0, sel},       8'd0);
        chk("first_valid", {7'd0, out_valid}, 8'd1);

        // Rotation with all requests held
        foreach (wins[k]) begin
            #1;
            chk($sformatf("rot_gnt%0d", k), {4'd0, gnt}, 8'(4'b0001 << wins[k]));
            push(2'(wins[k]), 4'(wins[k] + 1));
            step();
            chk($sformatf("rot_sel%0d", k), {6'd0, sel}, 8'(wins[k]));
        end

        // Skip and wrap: last grant was 2, pointer at 3
        req = 4'b0011;
        #1;
        chk("wrap_gnt", {4'd0, gnt}, 8'h01);
        push(2'd0, 4'h1);
        step();
        chk("wrap_sel", {6'd0, sel}, 8'd0);

        // Backpressure: capture c = A, then stall
        c = 4'hA; req = 4'b0100;
        #1;
        chk("bp_cap_gnt", {4'd0, gnt}, 8'h04);
        push(2'd2, 4'hA);
        step();
        out_ready = 1'b0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_gnt",   {4'd0, gnt},       8'h00);
            chk("bp_data",  {4'd0, out_data},  8'h0A);
            chk("bp_sel",   {6'd0, sel},       8'd2);
            chk("bp_valid", {7'd0, out_valid}, 8'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_gnt", {4'd0, gnt}, 8'h08);
        push(2'd3, 4'h4);
        step();

        // Drain
        req = 4'b0000;
        #1;
        chk("drain_gnt", {4'd0, gnt}, 8'h00);
        step();
        chk("drain_valid", {7'd0, out_valid}, 8'd0);
        chk("drain_data",  {4'd0, out_data},  8'h04);
        chk("drain_sel",   {6'd0, sel},       8'd3);

        // Fill then stall, then reset between edges
        req = 4'b0010;
        #1;
        chk("fill_gnt", {4'd0, gnt}, 8'h02);
        push(2'd1, 4'h2);
        step();
        out_ready = 1'b0; req = 4'b0000;
        step();
        chk("stall_valid", {7'd0, out_valid}, 8'd1);
        rst_n = 1'b0; req = 4'b1111;
        #1;
        chk("mrst_valid", {7'd0, out_valid}, 8'd0);
        chk("mrst_data",  {4'd0, out_data},  8'h00);
        chk("mrst_sel",   {6'd0, sel},       8'd0);
        chk("mrst_gnt",   {4'd0, gnt},       8'h00);
        exp_q.delete();
        #2;
        rst_n = 1'b1; out_ready = 1'b1; req = 4'b1001;
        #2;
        // Pointer back at 0 picks channel 0, not channel 3
        chk("mrst_gnt_1001", {4'd0, gnt}, 8'h01);
        push(2'd0, 4'h1);
        step();
        req = 4'b1000;
        #1;
        chk("mrst_gnt_1000", {4'd0, gnt}, 8'h08);
        push(2'd3, 4'h4);
        step();
        req = 4'b1001;
        #1;
        chk("mrst_gnt_wrap", {4'd0, gnt}, 8'h01);
        push(2'd0, 4'h1);
        step();
        req = 4'b0000;
        step();
        step();
        chk("end_valid", {7'd0, out_valid}, 8'd0);
        chk("end_queue", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
